elevator_ctrl: RTL and testbench



---
 rtl/elevator_ctrl.sv | 152 +++++++++++++++
 tb/tb_elevator_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/elevator_ctrl.sv
// Four-floor elevator controller: latches floor calls and serves them with a
// SCAN policy. Drives a registered one-hot floor indication.
module elevator_ctrl #(
    parameter int unsigned FLOOR_TIME = 2,
    parameter int unsigned DOOR_TIME  = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic ip_ground,
    input  logic ip_first,
    input  logic ip_second,
    input  logic ip_third,
    output logic op_ground,
    output logic op_first,
    output logic op_second,
    output logic op_third
);

    localparam int unsigned MaxTime = (FLOOR_TIME > DOOR_TIME) ? FLOOR_TIME : DOOR_TIME;
    localparam int unsigned CntW    = (MaxTime > 1) ? $clog2(MaxTime) : 1;

    localparam logic [CntW-1:0] FloorLoad = CntW'(FLOOR_TIME - 1);
    localparam logic [CntW-1:0] DoorLoad  = CntW'(DOOR_TIME - 1);

    typedef enum logic [1:0] {
        StIdle,
        StMoveUp,
        StMoveDown,
        StDoor
    } state_e;

    state_e          state_q, state_d;
    logic [1:0]      floor_q, floor_d;
    logic [3:0]      req_q, req_d;
    logic [3:0]      oh_q, oh_d;
    logic [CntW-1:0] cnt_q, cnt_d;
    logic            dir_q, dir_d;   // 1 = up

    logic [3:0] ip_vec;
    logic [3:0] clr;
    logic       req_above;
    logic       req_below;

    // Pending calls strictly above / below the current floor.
    always_comb begin
        req_above = 1'b0;
        req_below = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (i > int'(floor_q)) req_above = req_above | req_q[i];
            if (i < int'(floor_q)) req_below = req_below | req_q[i];
        end
    end

    // Next-state, travel/dwell timing and request latch update.
    always_comb begin
        state_d = state_q;
        floor_d = floor_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        clr     = 4'b0000;
        ip_vec  = {ip_third, ip_second, ip_first, ip_ground};

        unique case (state_q)
            StIdle: begin
                if (req_q[floor_q]) begin
                    state_d = StDoor;
                    clr[floor_q] = 1'b1;
                    cnt_d = DoorLoad;
                end else if (req_above && dir_q) begin
                    state_d = StMoveUp;
                    cnt_d = FloorLoad;
                end else if (req_below) begin
                    state_d = StMoveDown;
                    dir_d = 1'b0;
                    cnt_d = FloorLoad;
                end else if (req_above) begin
                    state_d = StMoveUp;
                    dir_d = 1'b1;
                    cnt_d = FloorLoad;
                end
            end
            StMoveUp, StMoveDown: begin
                if ((state_q == StMoveUp && floor_q == 2'd3) ||
                    (state_q == StMoveDown && floor_q == 2'd0)) begin
                    // Unreachable in normal operation; recover safely.
                    state_d = StIdle;
                end else if (cnt_q == '0) begin
                    floor_d = (state_q == StMoveUp) ? floor_q + 2'd1 : floor_q - 2'd1;
                    if (req_q[floor_d]) begin
                        state_d = StDoor;
                        clr[floor_d] = 1'b1;
                        cnt_d = DoorLoad;
                    end else begin
                        cnt_d = FloorLoad;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            StDoor: begin
                // Calls for the floor we are standing at are absorbed.
                clr[floor_q] = 1'b1;
                if (cnt_q == '0) begin
                    cnt_d = FloorLoad;
                    if ((dir_q && req_above) || (!dir_q && req_below)) begin
                        state_d = dir_q ? StMoveUp : StMoveDown;
                    end else if (dir_q && req_below) begin
                        state_d = StMoveDown;
                        dir_d = 1'b0;
                    end else if (!dir_q && req_above) begin
                        state_d = StMoveUp;
                        dir_d = 1'b1;
                    end else begin
                        state_d = StIdle;
                    end
                end else begin
                    cnt_d = cnt_q - CntW'(1);
                end
            end
            default: state_d = StIdle;
        endcase

        // Clear of the served floor wins over a simultaneous call.
        req_d = (req_q | ip_vec) & ~clr;
        oh_d  = 4'b0001 << floor_d;
    end

    // State registers with asynchronous reset to ground floor.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
            floor_q <= 2'd0;
            req_q   <= 4'b0000;
            oh_q    <= 4'b0001;
            cnt_q   <= '0;
            dir_q   <= 1'b1;
        end else begin
            state_q <= state_d;
            floor_q <= floor_d;
            req_q   <= req_d;
            oh_q    <= oh_d;
            cnt_q   <= cnt_d;
            dir_q   <= dir_d;
        end
    end

    assign op_ground = oh_q[0];
    assign op_first  = oh_q[1];
    assign op_second = oh_q[2];
    assign op_third  = oh_q[3];

endmodule

// File: tb/tb_elevator_ctrl.sv
// Self-checking bench for elevator_ctrl: directed scenarios with literal
// expectations plus randomized calls against a behavioural car model.
module tb_elevator_ctrl;

    localparam int FT = 2;
    localparam int DT = 2;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic ip_ground = 1'b0, ip_first = 1'b0, ip_second = 1'b0, ip_third = 1'b0;
    logic op_ground, op_first, op_second, op_third;

    int checks = 0;
    int failures = 0;
    bit chk_en = 1'b0;

    elevator_ctrl #(.FLOOR_TIME(FT), .DOOR_TIME(DT)) dut (
        .clk       (clk),
        .rst       (rst),
        .ip_ground (ip_ground),
        .ip_first  (ip_first),
        .ip_second (ip_second),
        .ip_third  (ip_third),
        .op_ground (op_ground),
        .op_first  (op_first),
        .op_second (op_second),
        .op_third  (op_third)
    );

    always #5 clk = ~clk;

    // Behavioural car model: activity 0 = parked, 1 = travelling, 2 = dwelling.
    // m_wait counts edges remaining until the current activity completes.
    bit m_req[4];
    int m_floor = 0;
    int m_dir = 1;
    int m_act = 0;
    int m_wait = 0;

    function automatic bit calls_toward(int from, int d);
        for (int f = from + d; f >= 0 && f <= 3; f += d)
            if (m_req[f]) return 1'b1;
        return 1'b0;
    endfunction

    task automatic start_travel(int d);
        m_act = 1;
        m_dir = d;
        m_wait = FT;
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) m_req[i] = 1'b0;
            m_floor = 0; m_dir = 1; m_act = 0; m_wait = 0;
        end else begin
            int served;
            bit ips[4];
            served = -1;
            ips[0] = ip_ground; ips[1] = ip_first; ips[2] = ip_second; ips[3] = ip_third;
            case (m_act)
                0: begin
                    if (m_req[m_floor]) begin
                        m_act = 2; m_wait = DT; served = m_floor;
                    end else if (m_dir == 1 && calls_toward(m_floor, 1)) start_travel(1);
                    else if (calls_toward(m_floor, -1)) start_travel(-1);
                    else if (calls_toward(m_floor, 1)) start_travel(1);
                end
                1: begin
                    if (m_floor + m_dir < 0 || m_floor + m_dir > 3) m_act = 0;
                    else begin
                        m_wait--;
                        if (m_wait == 0) begin
                            m_floor += m_dir;
                            if (m_req[m_floor]) begin
                                m_act = 2; m_wait = DT; served = m_floor;
                            end else m_wait = FT;
                        end
                    end
                end
                default: begin
                    served = m_floor;
                    m_wait--;
                    if (m_wait == 0) begin
                        if (calls_toward(m_floor, m_dir)) start_travel(m_dir);
                        else if (calls_toward(m_floor, -m_dir)) start_travel(-m_dir);
                        else m_act = 0;
                    end
                end
            endcase
            for (int i = 0; i < 4; i++) m_req[i] = m_req[i] | ips[i];
            if (served >= 0) m_req[served] = 1'b0;
        end
    end

    function automatic logic [3:0] dut_oh();
        return {op_third, op_second, op_first, op_ground};
    endfunction

    function automatic logic [3:0] model_oh();
        logic [3:0] v;
        v = 4'b0001 << m_floor;
        return v;
    endfunction

    // Per-cycle comparison of DUT floor lamps against the model.
    always @(negedge clk) begin
        if (chk_en) begin
            checks++;
            if (dut_oh() !== model_oh() || !$onehot(dut_oh())) begin
                failures++;
                $display("FAIL cycle_compare t=%0t dut=%b model=%b", $time, dut_oh(), model_oh());
            end
        end
    end

    // Literal expectation checked against both the DUT and the model.
    task automatic check_lit(input string name, input logic [3:0] exp);
        checks++;
        if (dut_oh() !== exp) begin
            failures++;
            $display("FAIL %s dut=%b expected=%b", name, dut_oh(), exp);
        end
        checks++;
        if (model_oh() !== exp) begin
            failures++;
            $display("FAIL %s_model model=%b expected=%b", name, model_oh(), exp);
        end
    endtask

    task automatic set_ip(input logic [3:0] v);
        {ip_third, ip_second, ip_first, ip_ground} = v;
    endtask

    // Drive calls for exactly one sampling edge; returns just after that edge.
    task automatic pulse(input logic [3:0] v);
        set_ip(v);
        @(negedge clk);
        set_ip(4'b0000);
    endtask

    task automatic wait_n(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    initial begin
        #1 rst = 1'b1;
        #1 chk_en = 1'b1;
        wait_n(2);
        check_lit("reset_state", 4'b0001);
        rst = 1'b0;
        wait_n(3);
        check_lit("idle_no_calls", 4'b0001);

        // Mid-travel asynchronous reset; calls during reset are ignored.
        pulse(4'b1000);
        wait_n(4);
        check_lit("travel_first", 4'b0010);
        #2 rst = 1'b1;
        ip_third = 1'b1;
        #1 check_lit("async_reset", 4'b0001);
        @(negedge clk);
        ip_third = 1'b0;
        rst = 1'b0;
        wait_n(20);
        check_lit("post_reset_idle", 4'b0001);

        // Current-floor call: dwell only, no movement.
        pulse(4'b0001);
        check_lit("cur_floor_e1", 4'b0001);
        wait_n(3);
        check_lit("cur_floor_e4", 4'b0001);
        wait_n(10);
        check_lit("cur_floor_e14", 4'b0001);

        // Single call to third floor: one floor every two edges.
        pulse(4'b1000);
        wait_n(2);
        check_lit("single_e2", 4'b0001);
        wait_n(1);
        check_lit("single_e3", 4'b0010);
        wait_n(2);
        check_lit("single_e5", 4'b0100);
        wait_n(2);
        check_lit("single_e7", 4'b1000);
        wait_n(10);
        check_lit("single_idle3", 4'b1000);

        // All calls at floor 3: serve 3, then descend stopping at each floor.
        pulse(4'b1111);
        wait_n(4);
        check_lit("all_f4", 4'b1000);
        wait_n(1);
        check_lit("all_f5", 4'b0100);
        wait_n(4);
        check_lit("all_f9", 4'b0010);
        wait_n(4);
        check_lit("all_f13", 4'b0001);
        wait_n(10);

        // Two simultaneous calls from ground.
        pulse(4'b0110);
        wait_n(3);
        check_lit("multi_e3", 4'b0010);
        wait_n(3);
        check_lit("multi_e6", 4'b0010);
        wait_n(1);
        check_lit("multi_e7", 4'b0100);
        wait_n(13);
        check_lit("multi_idle2", 4'b0100);

        // SCAN order: calls behind and ahead while moving up.
        do_reset();
        wait_n(2);
        pulse(4'b1000);
        wait_n(3);
        pulse(4'b0101);
        wait_n(1);
        check_lit("scan_e5", 4'b0100);
        wait_n(4);
        check_lit("scan_e9", 4'b1000);
        wait_n(7);
        check_lit("scan_e16", 4'b0010);
        wait_n(1);
        check_lit("scan_e17", 4'b0001);
        wait_n(10);

        // Randomized calls with occasional resets.
        for (int c = 0; c < 4000; c++) begin
            logic [3:0] v;
            for (int b = 0; b < 4; b++) v[b] = ($urandom_range(0, 11) == 0);
            set_ip(v);
            if ($urandom_range(0, 599) == 0) rst = 1'b1;
            @(negedge clk);
            rst = 1'b0;
        end
        set_ip(4'b0000);
        wait_n(40);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
